// File: rtl/bus_pkg.sv
// bus_pkg: shared state type, error word and region-match helper for bus_fabric.
package bus_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACCESS,
        BUS_RESP
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

    // A region claims an address when the masked address equals the region base.
    function automatic logic addr_hit(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder: combinational priority decode of a CPU address against the
// base/mask region table. The lowest-numbered matching region wins.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       IDX_W      = 2,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0
) (
    input  logic [31:0]           i_addr,
    output logic                  o_hit,
    output logic [NUM_SLAVES-1:0] o_oneHot,
    output logic [IDX_W-1:0]      o_idx
);

    // Scan from the top index down so the lowest matching region is the one left standing.
    always_comb begin
        o_hit    = 1'b0;
        o_oneHot = '0;
        o_idx    = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (addr_hit(i_addr, SLAVE_BASE[i*32 +: 32], SLAVE_MASK[i*32 +: 32])) begin
                o_hit       = 1'b1;
                o_oneHot    = '0;
                o_oneHot[i] = 1'b1;
                o_idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: single-master, N-slave interconnect for the picorv32 native memory bus.
// Each CPU access is decoded against a base/mask table and forwarded to one slave;
// unmapped accesses get an error word and raise the sticky error flag.
// Optional build macro BUS_TIMEOUT_EN: abort a slave that stalls for TIMEOUT_CYCLES.
module bus_fabric
    import bus_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter int                       DATA_W         = 32,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'h0000_3000, 32'h0000_2000,
                                                          32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {4{32'hFFFF_F000}},
    parameter logic [DATA_W-1:0]        ERR_RDATA      = DATA_W'(BUS_ERR_RDATA),
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         m_valid_i,
    output logic                         m_ready_o,
    input  logic [31:0]                  m_addr_i,
    input  logic [DATA_W-1:0]            m_wdata_i,
    input  logic [DATA_W/8-1:0]          m_wstrb_i,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic [NUM_SLAVES-1:0]        s_valid_o,
    output logic [31:0]                  s_addr_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    output logic [DATA_W/8-1:0]          s_wstrb_o,
    input  logic [NUM_SLAVES-1:0]        s_ready_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
    output logic                         err_o,
    output logic [31:0]                  err_addr_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    bus_state_t            r_state;
    bus_state_t            w_nextState;
    logic                  w_hit;
    logic [NUM_SLAVES-1:0] w_oneHot;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_SLAVES-1:0] r_sValid;
    logic [31:0]           r_sAddr;
    logic [DATA_W-1:0]     r_sWdata;
    logic [STRB_W-1:0]     r_sWstrb;
    logic [DATA_W-1:0]     r_mRdata;
    logic                  r_err;
    logic [31:0]           r_errAddr;
    logic                  w_slaveReady;
    logic [DATA_W-1:0]     w_slaveRdata;
    logic                  w_timeout;
    logic                  w_miss;
    logic                  w_raiseErr;
    logic [31:0]           w_errAddr;

    bus_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .i_addr   (m_addr_i),
        .o_hit    (w_hit),
        .o_oneHot (w_oneHot),
        .o_idx    (w_idx)
    );

    // Pick the ready and read data of the slave latched for the current access only.
    always_comb begin
        w_slaveReady = 1'b0;
        w_slaveRdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_slaveReady = s_ready_i[i];
                w_slaveRdata = s_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] r_waitCnt;

    // Count wait states of the access in flight; restarted while idle so each access starts at zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_waitCnt <= '0;
        end else if (r_state != BUS_ACCESS) begin
            r_waitCnt <= '0;
        end else if (!w_slaveReady) begin
            r_waitCnt <= r_waitCnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == BUS_ACCESS) && !w_slaveReady &&
                       (r_waitCnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic [15:0] w_unusedTimeout;

    assign w_unusedTimeout = 16'(TIMEOUT_CYCLES);
    assign w_timeout       = 1'b0;
`endif

    assign w_miss     = (r_state == BUS_IDLE) && m_valid_i && !w_hit;
    assign w_raiseErr = w_miss || w_timeout;
    assign w_errAddr  = w_timeout ? r_sAddr : m_addr_i;

    // State register; reset drops any access in flight without a response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a miss skips straight to the response, a hit waits on its slave.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            BUS_IDLE: begin
                if (m_valid_i) begin
                    w_nextState = w_hit ? BUS_ACCESS : BUS_RESP;
                end
            end
            BUS_ACCESS: begin
                if (w_slaveReady || w_timeout) begin
                    w_nextState = BUS_RESP;
                end
            end
            BUS_RESP: begin
                w_nextState = BUS_IDLE;
            end
            default: begin
                w_nextState = BUS_IDLE;
            end
        endcase
    end

    // Request latching toward the slaves and read-data capture toward the CPU.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sValid <= '0;
            r_sAddr  <= '0;
            r_sWdata <= '0;
            r_sWstrb <= '0;
            r_idx    <= '0;
            r_mRdata <= '0;
        end else begin
            case (r_state)
                BUS_IDLE: begin
                    if (m_valid_i) begin
                        if (w_hit) begin
                            r_sValid <= w_oneHot;
                            r_sAddr  <= m_addr_i;
                            r_sWdata <= m_wdata_i;
                            r_sWstrb <= m_wstrb_i;
                            r_idx    <= w_idx;
                        end else begin
                            r_mRdata <= ERR_RDATA;
                        end
                    end
                end
                BUS_ACCESS: begin
                    if (w_slaveReady) begin
                        r_sValid <= '0;
                        r_mRdata <= w_slaveRdata;
                    end else if (w_timeout) begin
                        r_sValid <= '0;
                        r_mRdata <= ERR_RDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky error flag; the address is recorded only for the first error after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err     <= 1'b0;
            r_errAddr <= '0;
        end else if (w_raiseErr && !r_err) begin
            r_err     <= 1'b1;
            r_errAddr <= w_errAddr;
        end
    end

    assign m_ready_o  = (r_state == BUS_RESP);
    assign m_rdata_o  = r_mRdata;
    assign s_valid_o  = r_sValid;
    assign s_addr_o   = r_sAddr;
    assign s_wdata_o  = r_sWdata;
    assign s_wstrb_o  = r_sWstrb;
    assign err_o      = r_err;
    assign err_addr_o = r_errAddr;

endmodule
